// File: rtl/aes_pkg.sv
// aes_pkg
//   Shared AES definitions for the round datapath.
//   - row_t   : one 32-bit state row, byte [31:24] is column 0
//   - state_t : four rows, index 0 is row 0
//   - fsm_t   : control states of sub_shift_rows
//   - SBOX    : forward substitution table
package aes_pkg;

   typedef logic [31:0] row_t;
   typedef row_t [0:3] state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox
//   Combinational forward S-box lookup.
//   - val : byte to substitute
//   - sub : substituted byte
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] val,
   output logic [7:0] sub
);

   assign sub = SBOX[val];

endmodule

// File: rtl/sub_shift_rows.sv
// sub_shift_rows
//   Sequential SubBytes + ShiftRows stage. A captured 4x4 state is
//   substituted LANES bytes per cycle in place, then row-rotated into the
//   output registers and held until the downstream handshake.
//   - clk, rst_n           : clock, asynchronous active-low reset
//   - in_valid / in_ready  : input state handshake
//   - a, b, c, d           : input rows 0..3, byte [31:24] is column 0
//   - out_valid / out_ready: result handshake
//   - x, y, z, w           : result rows 0..3 after ShiftRows
module sub_shift_rows
   import aes_pkg::*;
#(
   parameter int LANES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   input  logic [31:0] d,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] x,
   output logic [31:0] y,
   output logic [31:0] z,
   output logic [31:0] w
);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
      $error("sub_shift_rows: LANES must be 1, 2, 4, 8 or 16");
   end

   localparam logic [4:0] STEP = 5'(LANES);
   localparam logic [4:0] LAST = 5'(16 - LANES);

   fsm_t             state, state_nx;
   logic [4:0]       cnt, cnt_nx;
   // byte k lives at work[k]: row k[3:2], column k[1:0]
   logic [0:15][7:0] work, work_nx, work_sub;
   logic [7:0]       sb_in  [LANES];
   logic [7:0]       sb_out [LANES];
   state_t           res;
   logic             load_out;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      aes_sbox u_sbox (
         .val (sb_in[g]),
         .sub (sb_out[g])
      );
   end

   // counter is always a multiple of LANES, so the group never straddles byte 15
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         sb_in[l] = work[cnt[3:0] + 4'(l)];
      end
   end

   always_comb begin
      work_sub = work;
      for (int l = 0; l < LANES; l++) begin
         work_sub[cnt[3:0] + 4'(l)] = sb_out[l];
      end
   end

   // ShiftRows: row r rotated left by r bytes
   always_comb begin
      res[0] = {work_sub[0],  work_sub[1],  work_sub[2],  work_sub[3]};
      res[1] = {work_sub[5],  work_sub[6],  work_sub[7],  work_sub[4]};
      res[2] = {work_sub[10], work_sub[11], work_sub[8],  work_sub[9]};
      res[3] = {work_sub[15], work_sub[12], work_sub[13], work_sub[14]};
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      work_nx   = work;
      load_out  = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               work_nx  = {a, b, c, d};
               cnt_nx   = '0;
               state_nx = SUB;
            end
         end
         SUB: begin
            if (cnt[4]) begin
               // out-of-range counter: bail out rather than index past byte 15
               state_nx = DONE;
               load_out = 1'b1;
            end else begin
               work_nx = work_sub;
               cnt_nx  = cnt + STEP;
               if (cnt == LAST) begin
                  state_nx = DONE;
                  load_out = 1'b1;
               end
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         work  <= '0;
         x     <= '0;
         y     <= '0;
         z     <= '0;
         w     <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         work  <= work_nx;
         if (load_out) begin
            x <= res[0];
            y <= res[1];
            z <= res[2];
            w <= res[3];
         end
      end
   end

endmodule

// File: doc/sub_shift_rows.md
# sub_shift_rows

Sequential SubBytes + ShiftRows stage of the AES round datapath. It sits directly upstream of `mix_columns` and consumes a 4×4 state presented as four 32-bit row words. It substitutes every byte through a shared S-box, a configurable number of bytes per cycle. It then rotates the rows and presents the result, row-for-row, on `x/y/z/w` ready to drive `mix_columns` inputs `a/b/c/d`.

## Interface
- `LANES`, default 1: S-box instances used per cycle. Legal values: 1, 2, 4, 8, 16. Any other value is a compile-time error.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input state valid.
- `in_ready`  out  1  block can accept a state.
- `a`, `b`, `c`, `d`  in  32 each  state rows 0..3. Byte `[31:24]` is column 0, `[7:0]` is column 3.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `x`, `y`, `z`, `w`  out  32 each  result rows 0..3, same byte order as the inputs.

## Operation
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, capture a,b,c,d into a 128-bit working register, clear the byte counter, and go to SUB.
  - Inputs may change freely after capture.
- SUB:
  - Each cycle, substitute bytes k..k+LANES-1 of the working register in place.
  - Byte index k maps to row k[3:2], column k[1:0].
  - The counter advances by LANES each cycle. Go to DONE on the cycle that processes the last group, k = 16-LANES.
- DONE:
  - Drive `out_valid`=1 with x/y/z/w from registered outputs. These are loaded on the SUB→DONE transition with ShiftRows applied.
  - Hold the outputs stable until `out_ready`=1. On that handshake, go to IDLE.
- ShiftRows rotates row r left by r bytes:
  - x = row0
  - y = {b1,b2,b3,b0}
  - z = {b2,b3,b0,b1}
  - w = {b3,b0,b1,b2}
  - bN is the substituted byte of column N in that row.
- S-box: the FIPS-197 forward table, purely combinational.
- `in_ready` is 0 in SUB and DONE. `out_valid` is 0 in IDLE and SUB.

## Timing
- Reset, async assert: state=IDLE, counter=0, working register=0, x/y/z/w=0, `out_valid`=0, `in_ready`=1 on deassertion.
- Reset mid-SUB or mid-DONE aborts the state. The result is discarded and never presented.
- Latency: acceptance edge E0. `out_valid` goes high after edge E(16/LANES).
  - LANES=1: 16 cycles.
  - LANES=16: 1 cycle.
- Throughput: one state per 16/LANES+2 cycles with `out_ready` tied high. This counts the SUB cycles, one DONE cycle and one IDLE cycle.
- `out_ready` asserted in IDLE or SUB has no effect.
- `in_valid` held high while `in_ready`=0 is ignored. The state is not captured until the next IDLE cycle.
- Counter width: 5 bits. It never wraps past 16. A counter value ≥16 in SUB is unreachable; if it occurs, force DONE.

## Structure
- Shared package `aes_pkg`: the 256-entry S-box constant array, a row-word type (32 bits), and a state type (4 rows).
- Sub-module `aes_sbox`: 8-bit in, 8-bit out, combinational lookup from `aes_pkg`. Instantiate it LANES times via generate.
- The ShiftRows rotation is inline wiring. It is not a sub-module.

## Test plan
- Reset with LANES=1 → x/y/z/w=0, `out_valid`=0, `in_ready`=1.
- All-zero state, LANES=1 → after 16 cycles, x=y=z=w=32'h63636363.
- a=b=c=d=32'h00010203 → x=32'h637c777b, y=32'h7c777b63, z=32'h777b637c, w=32'h7b637c77.
  - Repeat with LANES=1, 4 and 16.
  - Latencies must be 16, 4 and 1 cycles respectively.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`.
  - Outputs stay constant and `in_ready` stays 0.
  - A second state presented during this window is accepted only after the release handshake plus one IDLE cycle.
- a=32'hff535300, b=c=d=0 → x=32'h16eded63, and y=z=w=32'h63636363.
- Assert `rst_n` low at cycle 8 of SUB, then release and send a new zero state → only 32'h63636363 rows appear. No stale or partial result is ever presented.
